instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly downstream of the pre-programmed byte-wide program ROM in the MCU51 core.
- Drives the ROM chip select (active low) and address, then collects the 1–3 bytes of each MCS-51 instruction into an instruction register.
- Presents the assembled instruction to the decode/control stage with a valid/ready handshake.
- Accepts absolute branch redirects from the control stage.

Parameters:
- ADDRWIDTH, 8, width of the program address; the fetch address wraps modulo 2^ADDRWIDTH.
- RESET_PC, 0, address of the first opcode fetched after reset.

Ports:
- clk  in  1  core clock; the ROM registers its data on the falling edge.
- rst  in  1  reset, asynchronous, active-high.
- rom_cs_n  out  1  ROM chip select, low = read.
- rom_addr  out  ADDRWIDTH  ROM byte address.
- rom_data  in  8  ROM read data.
- ir_valid  out  1  instruction register holds a complete instruction.
- ir_ready  in  1  decode stage accepts the instruction.
- ir_op  out  8  opcode.
- ir_b1  out  8  second byte; 00 if absent.
- ir_b2  out  8  third byte; 00 if absent.
- ir_len  out  2  byte count, 1..3.
- ir_pc  out  ADDRWIDTH  address of the opcode.
- ir_npc  out  ADDRWIDTH  ir_pc+ir_len mod 2^ADDRWIDTH; this is the base for relative branches.
- br_valid  in  1  redirect request.
- br_target  in  ADDRWIDTH  absolute redirect address.

Behaviour:
- ROM timing: rom_addr is driven from register fa at the rising edge. The ROM latches at the falling edge in mid-cycle. The fetch unit samples rom_data at the next rising edge, giving 1 byte per cycle with zero wait states.
- rom_cs_n = 0 only in S_OP, S_B1 and S_B2, and only when rst = 0. rom_cs_n = 1 in S_VALID.
- Reset values: state = S_OP, fa = RESET_PC, ir_valid = 0, ir_op/b1/b2 = 00, ir_len = 1, ir_pc = RESET_PC, ir_npc = RESET_PC+1.
- S_OP:
  - Captures ir_op = rom_data and ir_pc = fa; clears ir_b1/ir_b2; fa += 1.
  - ir_len comes from the length table applied to rom_data.
  - Next state: S_VALID if length is 1, else S_B1.
- S_B1: captures ir_b1; fa += 1. Next state: S_VALID if length is 2, else S_B2.
- S_B2: captures ir_b2; fa += 1. Next state: S_VALID.
- S_VALID:
  - ir_valid = 1; all ir_* outputs are held stable.
  - When ir_ready = 1: next state S_OP, ir_valid = 0 from the next cycle.
  - Throughput: an L-byte instruction takes L+1 cycles.
- Length table (MCS-51):
  - 3 bytes: 02, 10, 12, 20, 30, 43, 53, 63, 75, 85, 90, B4–BF, D5.
  - 1 byte: 00, 03, 04, 06–0F, 13, 14, 16–1F, 22, 23, 26–2F, 32, 33, 36–3F, 46–4F, 56–5F, 66–6F, 73, 83, 84, 93, 96–9F, A3, A4, A5, B3, C3, C4, C6–CF, D3, D4, D6, D7, E0, E2–E4, E6–EF, F0, F2–F4, F6–FF.
  - All other opcodes: 2 bytes.
- Redirect:
  - br_valid = 1 in any state: at that edge fa = br_target, state = S_OP, ir_valid = 0 next cycle.
  - Any partially collected instruction and any byte captured in that cycle are discarded.
  - br_valid together with ir_ready in S_VALID: the instruction is consumed and the redirect still applies.
  - Redirect has priority over all normal transitions.
- Wrap: fa and ir_npc wrap FF→00 (ADDRWIDTH = 8), including inside a multi-byte instruction.
- Reset mid-operation: asynchronous return to reset values; the partial instruction is lost; rom_cs_n = 1 while rst is high.
- ir_ready while ir_valid = 0 is ignored.

Test Plan:
- Reset release, ROM holding 74 A5 C4 E4 at 00, ir_ready = 1:
  - ir_valid at cycle 3 with op 74, b1 A5, b2 00, len 2, pc 00, npc 02.
  - Then op C4, len 1, pc 02 two cycles later.
- 3-byte fetch from 08 (B4 07 F5): op B4, b1 07, b2 F5, len 3, pc 08, npc 0B; rom_addr steps 08, 09, 0A.
- Stall: hold ir_ready low 5 cycles in S_VALID:
  - outputs unchanged, rom_cs_n = 1, rom_addr constant;
  - one cycle after ir_ready rises, opcode fetch at npc.
- Redirect in S_B1 of the instruction at 0E, with br_target = 1D: the partial instruction is dropped; next ir = 85 30 90, pc 1D, npc 20.
- Wrap: br_target = FF, FF = 00 (NOP):
  - ir = 00, pc FF, npc 00;
  - next ir = 74 A5, pc 00.
- Async rst pulse mid-S_B2: ir_valid and rom_cs_n go to 0/1 immediately; after release the first fetch is at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// MCS-51 instruction fetch: byte-serial ROM reads assembled into an
// instruction register, with a valid/ready handshake and branch redirects.
module instr_fetch_unit #(
    parameter int ADDRWIDTH = 8,
    parameter logic [ADDRWIDTH-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 rom_cs_n,
    output logic [ADDRWIDTH-1:0] rom_addr,
    input  logic [7:0]           rom_data,
    output logic                 ir_valid,
    input  logic                 ir_ready,
    output logic [7:0]           ir_op,
    output logic [7:0]           ir_b1,
    output logic [7:0]           ir_b2,
    output logic [1:0]           ir_len,
    output logic [ADDRWIDTH-1:0] ir_pc,
    output logic [ADDRWIDTH-1:0] ir_npc,
    input  logic                 br_valid,
    input  logic [ADDRWIDTH-1:0] br_target
);

    localparam logic [1:0] S_OP    = 2'd0;
    localparam logic [1:0] S_B1    = 2'd1;
    localparam logic [1:0] S_B2    = 2'd2;
    localparam logic [1:0] S_VALID = 2'd3;

    logic [1:0]           state;
    logic [ADDRWIDTH-1:0] fa;
    logic [1:0]           len_d;

    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = op[7:4];
        lo = op[3:0];
        if (op inside {8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53,
                       8'h63, 8'h75, 8'h85, 8'h90, 8'hD5} ||
            (hi == 4'hB && lo >= 4'h4))
            op_len = 2'd3;
        else if (op inside {8'h00, 8'h03, 8'h04, 8'h13, 8'h14, 8'h22,
                            8'h23, 8'h32, 8'h33, 8'h73, 8'h83, 8'h84,
                            8'h93, 8'hA3, 8'hA4, 8'hA5, 8'hB3, 8'hC3,
                            8'hC4, 8'hD3, 8'hD4, 8'hD6, 8'hD7, 8'hE0,
                            8'hE2, 8'hE3, 8'hE4, 8'hF0, 8'hF2, 8'hF3,
                            8'hF4} ||
                 (lo >= 4'h6 && hi inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                                            4'h5, 4'h6, 4'h9, 4'hC, 4'hE,
                                            4'hF}))
            op_len = 2'd1;
        else
            op_len = 2'd2;
    endfunction

    assign len_d    = op_len(rom_data);
    assign rom_addr = fa;
    assign ir_valid = (state == S_VALID);
    // The ROM is only selected while a byte is being collected.
    assign rom_cs_n = rst | (state == S_VALID);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_OP;
            fa     <= RESET_PC;
            ir_op  <= 8'h00;
            ir_b1  <= 8'h00;
            ir_b2  <= 8'h00;
            ir_len <= 2'd1;
            ir_pc  <= RESET_PC;
            ir_npc <= RESET_PC + ADDRWIDTH'(1);
        end else if (br_valid) begin
            // Redirect drops any byte collected in this cycle.
            fa    <= br_target;
            state <= S_OP;
        end else begin
            case (state)
                S_OP: begin
                    ir_op  <= rom_data;
                    ir_pc  <= fa;
                    ir_b1  <= 8'h00;
                    ir_b2  <= 8'h00;
                    ir_len <= len_d;
                    ir_npc <= fa + ADDRWIDTH'(len_d);
                    fa     <= fa + ADDRWIDTH'(1);
                    state  <= (len_d == 2'd1) ? S_VALID : S_B1;
                end
                S_B1: begin
                    ir_b1 <= rom_data;
                    fa    <= fa + ADDRWIDTH'(1);
                    state <= (ir_len == 2'd2) ? S_VALID : S_B2;
                end
                S_B2: begin
                    ir_b2 <= rom_data;
                    fa    <= fa + ADDRWIDTH'(1);
                    state <= S_VALID;
                end
                S_VALID: begin
                    if (ir_ready)
                        state <= S_OP;
                end
                default: state <= S_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a falling-edge ROM model.
module tb_instr_fetch_unit;

    logic       clk;
    logic       rst;
    logic       rom_cs_n;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       ir_valid;
    logic       ir_ready;
    logic [7:0] ir_op;
    logic [7:0] ir_b1;
    logic [7:0] ir_b2;
    logic [1:0] ir_len;
    logic [7:0] ir_pc;
    logic [7:0] ir_npc;
    logic       br_valid;
    logic [7:0] br_target;

    logic [7:0] rom [256];
    int checks;
    int failures;

    instr_fetch_unit #(.ADDRWIDTH(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .rom_cs_n(rom_cs_n), .rom_addr(rom_addr),
        .rom_data(rom_data), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .ir_op(ir_op), .ir_b1(ir_b1), .ir_b2(ir_b2), .ir_len(ir_len),
        .ir_pc(ir_pc), .ir_npc(ir_npc), .br_valid(br_valid),
        .br_target(br_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rom_cs_n)
            rom_data <= rom[rom_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ir(input string tag, input logic [7:0] op,
                          input logic [7:0] b1, input logic [7:0] b2,
                          input logic [1:0] len, input logic [7:0] pc,
                          input logic [7:0] npc);
        chk({tag, "_valid"}, 32'(ir_valid), 32'd1);
        chk({tag, "_op"}, 32'(ir_op), 32'(op));
        chk({tag, "_b1"}, 32'(ir_b1), 32'(b1));
        chk({tag, "_b2"}, 32'(ir_b2), 32'(b2));
        chk({tag, "_len"}, 32'(ir_len), 32'(len));
        chk({tag, "_pc"}, 32'(ir_pc), 32'(pc));
        chk({tag, "_npc"}, 32'(ir_npc), 32'(npc));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[8'h00] = 8'h74; rom[8'h01] = 8'hA5;
        rom[8'h02] = 8'hC4; rom[8'h03] = 8'hE4;
        rom[8'h08] = 8'hB4; rom[8'h09] = 8'h07; rom[8'h0A] = 8'hF5;
        rom[8'h0E] = 8'h74; rom[8'h0F] = 8'h55;
        rom[8'h1D] = 8'h85; rom[8'h1E] = 8'h30; rom[8'h1F] = 8'h90;
        rom_data  = 8'h00;
        rst       = 1'b1;
        ir_ready  = 1'b1;
        br_valid  = 1'b0;
        br_target = 8'h00;

        tick();
        tick();
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_cs", 32'(rom_cs_n), 32'd1);
        chk("rst_addr", 32'(rom_addr), 32'h00);
        chk("rst_len", 32'(ir_len), 32'd1);
        chk("rst_pc", 32'(ir_pc), 32'h00);
        chk("rst_npc", 32'(ir_npc), 32'h01);
        chk("rst_op", 32'(ir_op), 32'h00);
        rst = 1'b0;
        #1;
        chk("rel_cs", 32'(rom_cs_n), 32'd0);

        tick();
        chk("b1_valid", 32'(ir_valid), 32'd0);
        chk("b1_addr", 32'(rom_addr), 32'h01);
        tick();
        chk_ir("ir74", 8'h74, 8'hA5, 8'h00, 2'd2, 8'h00, 8'h02);
        chk("ir74_cs", 32'(rom_cs_n), 32'd1);
        tick();
        chk("op2_valid", 32'(ir_valid), 32'd0);
        tick();
        chk_ir("irC4", 8'hC4, 8'h00, 8'h00, 2'd1, 8'h02, 8'h03);

        // consume C4 and redirect in the same cycle
        br_valid  = 1'b1;
        br_target = 8'h08;
        tick();
        br_valid = 1'b0;
        chk("r08_valid", 32'(ir_valid), 32'd0);
        chk("r08_addr0", 32'(rom_addr), 32'h08);
        tick();
        chk("r08_addr1", 32'(rom_addr), 32'h09);
        tick();
        chk("r08_addr2", 32'(rom_addr), 32'h0A);
        tick();
        chk_ir("irB4", 8'hB4, 8'h07, 8'hF5, 2'd3, 8'h08, 8'h0B);

        ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_ir("stall", 8'hB4, 8'h07, 8'hF5, 2'd3, 8'h08, 8'h0B);
            chk("stall_cs", 32'(rom_cs_n), 32'd1);
            chk("stall_addr", 32'(rom_addr), 32'h0B);
        end
        ir_ready = 1'b1;
        tick();
        chk("unstall_valid", 32'(ir_valid), 32'd0);
        chk("unstall_cs", 32'(rom_cs_n), 32'd0);
        chk("unstall_addr", 32'(rom_addr), 32'h0B);

        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ir("nop", 8'h00, 8'h00, 8'h00, 2'd1, 8'(8'h0B + i),
                   8'(8'h0C + i));
            tick();
        end
        tick();
        chk("b1_0E_valid", 32'(ir_valid), 32'd0);
        chk("b1_0E_addr", 32'(rom_addr), 32'h0F);
        br_valid  = 1'b1;
        br_target = 8'h1D;
        tick();
        br_valid = 1'b0;
        chk("r1D_valid", 32'(ir_valid), 32'd0);
        chk("r1D_addr", 32'(rom_addr), 32'h1D);
        tick();
        tick();
        tick();
        chk_ir("ir85", 8'h85, 8'h30, 8'h90, 2'd3, 8'h1D, 8'h20);

        br_valid  = 1'b1;
        br_target = 8'hFF;
        tick();
        br_valid = 1'b0;
        chk("rFF_addr", 32'(rom_addr), 32'hFF);
        tick();
        chk_ir("irFF", 8'h00, 8'h00, 8'h00, 2'd1, 8'hFF, 8'h00);
        tick();
        chk("wrap_addr", 32'(rom_addr), 32'h00);
        tick();
        tick();
        chk_ir("wrap74", 8'h74, 8'hA5, 8'h00, 2'd2, 8'h00, 8'h02);

        br_valid  = 1'b1;
        br_target = 8'h08;
        tick();
        br_valid = 1'b0;
        tick();
        tick();
        chk("b2_addr", 32'(rom_addr), 32'h0A);
        chk("b2_cs", 32'(rom_cs_n), 32'd0);
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(ir_valid), 32'd0);
        chk("arst_cs", 32'(rom_cs_n), 32'd1);
        chk("arst_addr", 32'(rom_addr), 32'h00);
        chk("arst_len", 32'(ir_len), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("arel_addr", 32'(rom_addr), 32'h01);
        chk("arel_op", 32'(ir_op), 32'h74);
        tick();
        chk_ir("arel74", 8'h74, 8'hA5, 8'h00, 2'd2, 8'h00, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
